// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexed driver for a common-anode 7-segment display.
// Scans NUM_DIGITS packed BCD digits, one digit lit at a time, all outputs active-low.
// The digits and decimal points are latched once per frame, so a carry in the
// upstream counter chain cannot tear the displayed value.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_display #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    cr,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_sync
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic                    tick;
    logic                    frame_end;

    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;

    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dp_d;

    // Active-low 7-segment decode, {g,f,e,d,c,b,a}; non-BCD codes are blank.
    function automatic logic [6:0] decode(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign tick      = en && (prescaler_q == PRE_LAST);
    assign frame_end = tick && (index_q == IDX_LAST);

    // Prescaler and digit index next-state; both hold while en is low.
    always_comb begin
        prescaler_d = prescaler_q;
        index_d     = index_q;
        if (en) begin
            if (prescaler_q == PRE_LAST) begin
                prescaler_d = '0;
            end else begin
                prescaler_d = prescaler_q + PRE_W'(1);
            end
        end
        if (tick) begin
            if (index_q == IDX_LAST) begin
                index_d = '0;
            end else begin
                index_d = index_q + IDX_W'(1);
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank while it and every higher snapshot digit are zero; digit 0 never is.
    always_comb begin
        logic hi_zero;
        blank_mask = '0;
        hi_zero    = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            hi_zero       = hi_zero && (snap_digits_q[4*k +: 4] == 4'd0);
            blank_mask[k] = hi_zero;
        end
    end
`else
    assign blank_mask = '0;
`endif

    // Select the snapshot digit, decimal point and blank flag at the current index.
    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (index_q == IDX_W'(k)) begin
                cur_digit = snap_digits_q[4*k +: 4];
                cur_dp    = snap_dp_q[k];
                cur_blank = blank_mask[k];
            end
        end
    end

    // Next values of the registered display outputs.
    always_comb begin
        an_d = '1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            an_d[k] = (index_q != IDX_W'(k));
        end
        seg_d = cur_blank ? 7'h7F : decode(cur_digit);
        dp_d  = ~cur_dp;
    end

    // Scan state and frame snapshot; the snapshot only loads at the end of a frame.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            prescaler_q   <= '0;
            index_q       <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            index_q     <= index_d;
            if (frame_end) begin
                snap_digits_q <= digits_in;
                snap_dp_q     <= dp_in;
            end
        end
    end

    // Registered outputs: one cycle behind the index and snapshot.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_sync <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_sync <= frame_end;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Testbench for bcd_scan_display (NUM_DIGITS=4, SCAN_DIV=4): directed vectors, a
// frame-level reference model checked every cycle, and hand-computed literal checks.
module tb_bcd_scan_display;

    localparam int N = 4;
    localparam int D = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    logic          clk;
    logic          cr;
    logic          en;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_sync;

    int n_checks;
    int n_fail;
    logic checking;

    bcd_scan_display #(
        .NUM_DIGITS(N),
        .SCAN_DIV  (D)
    ) dut (
        .clk       (clk),
        .cr        (cr),
        .en        (en),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_sync(frame_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: the scan position is simply the count of enabled cycles since
    // reset divided by the digit time; a frame is N digit times long.
    int          m_cnt;
    int          m_pos;
    logic [15:0] m_snap;
    logic [3:0]  m_snap_dp;
    logic        m_blank;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fs;

    always @(posedge clk or negedge cr) begin
        if (!cr) begin
            m_cnt     = 0;
            m_snap    = '0;
            m_snap_dp = '0;
            e_an      = 4'hF;
            e_seg     = 7'h7F;
            e_dp      = 1'b1;
            e_fs      = 1'b0;
        end else begin
            m_pos = (m_cnt / D) % N;
`ifdef LEADING_ZERO_BLANK_EN
            m_blank = (m_pos > 0) && ((m_snap >> (4 * m_pos)) == 16'd0);
`else
            m_blank = 1'b0;
`endif
            e_an  = ~(4'b0001 << m_pos);
            e_seg = m_blank ? 7'h7F : SEG_TAB[4'((m_snap >> (4 * m_pos)) & 16'hF)];
            e_dp  = ~m_snap_dp[m_pos];
            e_fs  = en && ((m_cnt % (N * D)) == N * D - 1);
            if (e_fs) begin
                m_snap    = digits_in;
                m_snap_dp = dp_in;
            end
            if (en) m_cnt++;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("model_an", 32'(an), 32'(e_an));
            check("model_seg", 32'(seg), 32'(e_seg));
            check("model_dp", 32'(dp), 32'(e_dp));
            check("model_frame_sync", 32'(frame_sync), 32'(e_fs));
        end
    end

    task automatic wait_fs(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (frame_sync) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic wait_an(input string name, input logic [3:0] target, output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            cycles++;
            if (an == target) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        int cyc;
        n_checks  = 0;
        n_fail    = 0;
        checking  = 1'b0;
        cr        = 1'b1;
        en        = 1'b1;
        digits_in = '0;
        dp_in     = '0;
        #1 cr = 1'b0;
        repeat (2) @(negedge clk);
        checking = 1'b1;

        // Reset values while the clock runs
        check("rst_an", 32'(an), 32'h0F);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_fs", 32'(frame_sync), 32'd0);

        // First frame shows zeros
        cr = 1'b1;
        @(negedge clk);
        check("first_an", 32'(an), 32'h0E);
        check("first_seg", 32'(seg), 32'h40);
        digits_in = 16'h1234;
        dp_in     = 4'b0100;
        repeat (4) @(negedge clk);
        check("step_an_d", 32'(an), 32'h0D);
        check("step_seg_d", 32'(seg), 32'h40);
        repeat (4) @(negedge clk);
        check("step_an_b", 32'(an), 32'h0B);
        repeat (4) @(negedge clk);
        check("step_an_7", 32'(an), 32'h07);
        wait_fs("wait_fs1");

        // Frame with 1234
        @(negedge clk);
        check("f1_an0", 32'(an), 32'h0E);
        check("f1_seg0", 32'(seg), 32'h19);
        check("f1_dp0", 32'(dp), 32'd1);
        repeat (4) @(negedge clk);
        check("f1_an1", 32'(an), 32'h0D);
        check("f1_seg1", 32'(seg), 32'h30);
        // Change inputs mid-frame
        digits_in = 16'h5678;
        repeat (4) @(negedge clk);
        check("tear_seg2", 32'(seg), 32'h24);
        check("tear_dp2", 32'(dp), 32'd0);
        repeat (4) @(negedge clk);
        check("tear_seg3", 32'(seg), 32'h79);
        wait_fs("wait_fs2");
        @(negedge clk);
        check("f2_seg0", 32'(seg), 32'h00);
        repeat (4) @(negedge clk);
        check("f2_an1", 32'(an), 32'h0D);
        check("f2_seg1", 32'(seg), 32'h78);

        // Enable hold
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_an", 32'(an), 32'h0D);
        check("hold_seg", 32'(seg), 32'h78);
        en = 1'b1;
        wait_an("resume_reach_b", 4'hB, cyc);
        check("resume_cycles", 32'(cyc), 32'd4);

        // Illegal BCD in digit 2
        digits_in = 16'h1C34;
        wait_fs("wait_fs3");
        wait_an("ill_reach_b", 4'hB, cyc);
        check("ill_seg2", 32'(seg), 32'h7F);
        wait_an("ill_reach_7", 4'h7, cyc);
        check("ill_seg3", 32'(seg), 32'h79);

        // Asynchronous reset between edges
        @(negedge clk);
        #2 cr = 1'b0;
        #1;
        check("async_an", 32'(an), 32'h0F);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 32'd1);
        check("async_fs", 32'(frame_sync), 32'd0);
        #1 cr = 1'b1;
        digits_in = 16'h0070;
        dp_in     = 4'b1000;
        wait_fs("wait_fs4");
        @(negedge clk);
        check("lz_seg0", 32'(seg), 32'h40);
        repeat (4) @(negedge clk);
        check("lz_seg1", 32'(seg), 32'h78);
        repeat (4) @(negedge clk);
        check("lz_an2", 32'(an), 32'h0B);
        check("lz_seg2", 32'(seg), 32'(LZ_SEG));
        check("lz_dp2", 32'(dp), 32'd1);
        repeat (4) @(negedge clk);
        check("lz_seg3", 32'(seg), 32'(LZ_SEG));
        check("lz_dp3", 32'(dp), 32'd0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the clock's BCD counter chain.
- Takes NUM_DIGITS packed BCD digits plus per-digit decimal points and time-multiplexes them onto a common-anode 7-segment display: one digit enabled at a time, active-low anodes and segments.
- Each frame uses a snapshot of the inputs, so a counter carry mid-frame never tears the displayed value.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..8).
- SCAN_DIV, 50000, clk cycles each digit stays lit (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- cr  input  1  asynchronous active-low clear.
- en  input  1  scan enable; low freezes the scan position.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit k = digits_in[4k+3:4k]; digit 0 = least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
- an  output  NUM_DIGITS  anode select, active-low, registered.
- seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
- dp  output  1  decimal point, active-low, registered.
- frame_sync  output  1  one-cycle pulse when a new snapshot is captured.

Behaviour:
- Reset (cr low, asynchronous):
  - prescaler=0, index=0, snapshot digits=0, snapshot dp=0.
  - an=all ones, seg=7'h7F, dp=1, frame_sync=0.
- Prescaler:
  - While en=1, counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (en && prescaler==SCAN_DIV-1).
- Index:
  - On tick, index increments.
  - From NUM_DIGITS-1 it wraps to 0.
- Snapshot and frame_sync:
  - On a tick where index==NUM_DIGITS-1, the snapshot loads digits_in/dp_in.
  - frame_sync=1 for exactly that next cycle.
  - No other event loads the snapshot, so the first frame after reset shows all zeros.
- Outputs (registered every cycle from the current index and snapshot, one-cycle latency):
  - an = ~(1<<index).
  - seg = decode(snapshot digit[index]).
  - dp = ~snapshot dp[index].
  - First cycle after cr rises: an=~1, seg=7'h40.
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Codes 10-15 are illegal BCD and give blank (7F).
- en=0:
  - Prescaler and index hold; outputs keep showing the current digit (no blanking).
  - frame_sync stays 0.
  - Scanning resumes from the held prescaler value.
- digits_in changing mid-frame: no visible effect until the next snapshot.
- Reset mid-frame: all state returns to the reset values immediately, regardless of clk.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits from NUM_DIGITS-1 downward are blanked (seg=7F) while they and every higher digit in the snapshot are 0.
  - Digit 0 is never blanked.
  - dp of a blanked digit still follows dp_in.
  - The blank mask is computed from the snapshot, so it too changes only at frame boundaries.
- Undefined: every digit is always decoded; zeros are shown as "0".

Test Plan:
- Reset/first frame (NUM_DIGITS=4, SCAN_DIV=4): assert cr low with clk running -> an=4'hF, seg=7F, dp=1 immediately; release -> next cycle an=4'hE, seg=40; an steps E,D,B,7 every 4 cycles, then back to E.
- Snapshot: digits_in=16'h1234, dp_in=4'b0100 before the first wrap -> frame_sync single pulse at the wrap; next frame shows digit0 seg=19, digit1 seg=30, digit2 seg=24 with dp=0, digit3 seg=79.
- Tear-free: change digits_in to 16'h5678 while index=1 -> remaining digits of the frame still show 1234; the next frame shows 5678.
- Enable hold: drop en for 10 cycles while an=4'hD -> an, seg and prescaler frozen, no frame_sync; raise en -> advance to an=4'hB after the remaining prescaler count.
- Illegal code: digit2=4'hC -> seg=7F at index 2 only.
- Async reset mid-scan plus leading-zero blanking (with LEADING_ZERO_BLANK_EN defined): pulse cr between clk edges -> outputs return to reset values at once. With digits_in=16'h0070 -> digit3 blank, digit2 blank, digit1 seg=78, digit0 seg=40.
